// File: rtl/sampmerge_pkg.sv
// Shared definitions for the sample merger: register map, trigger modes and
// the round-robin index helper used by the arbiter.
package sampmerge_pkg;

    localparam logic [7:0] ADDR_ENABLE   = 8'h00;
    localparam logic [7:0] ADDR_DECIM    = 8'h01;
    localparam logic [7:0] ADDR_TRIGMODE = 8'h02;
    localparam logic [7:0] ADDR_OVERFLOW = 8'h03;

    typedef enum logic [1:0] {
        TRIG_OFF  = 2'd0,
        TRIG_OR   = 2'd1,
        TRIG_AND  = 2'd2,
        TRIG_RSVD = 2'd3
    } trig_mode_e;

    // (base + offset) modulo n, for base and offset both below n.
    function automatic int wrap_idx(input int base, input int offset, input int n);
        int s;
        s = base + offset;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/sampmerge_fifo.sv
// Per-channel sample buffer: power-of-two depth, flush, and a push that is
// accepted into a full buffer when a pop happens in the same cycle.
module sampfifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers define validity, and
    // leaving the array out of reset keeps it mappable onto plain RAM/regfile cells.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sampmerge.sv
// Multi-channel sample merger: per-channel decimation and buffering, round-robin
// merge onto one registered output, combined trigger, wishbone register block.
module sampmerge
    import sampmerge_pkg::*;
#(
    parameter int NUM_SOURCES  = 4,
    parameter int SAMPLE_WIDTH = 32,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_SOURCES*SAMPLE_WIDTH-1:0] sources,
    input  logic [NUM_SOURCES-1:0]              avails,
    input  logic [NUM_SOURCES-1:0]              triggers,
    input  logic                                sq_active,
    output logic [SAMPLE_WIDTH-1:0]             sample,
    output logic                                sample_avail,
    output logic [2:0]                          sample_chan,
    output logic                                sq_trigger,
    input  logic                                wb_stb_i,
    input  logic                                wb_cyc_i,
    input  logic                                wb_we_i,
    input  logic [15:0]                         wb_adr_i,
    input  logic [7:0]                          wb_dat_i,
    output logic [7:0]                          wb_dat_o,
    output logic                                wb_ack_o
);

    localparam int CW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

    logic [NUM_SOURCES-1:0]  enable_q;
    logic [NUM_SOURCES-1:0]  overflow_q;
    logic [7:0]              decim_q;
    logic [1:0]              trigmode_q;
    logic                    wb_req;
    logic                    reg_wr;
    logic [7:0]              rd_data;
    logic                    unused_adr;

    logic [7:0]              dec_cnt [NUM_SOURCES];
    logic [NUM_SOURCES-1:0]  chan_hit;
    logic [NUM_SOURCES-1:0]  accept;
    logic [NUM_SOURCES-1:0]  fifo_push;
    logic [NUM_SOURCES-1:0]  fifo_pop;
    logic [NUM_SOURCES-1:0]  fifo_full;
    logic [NUM_SOURCES-1:0]  fifo_empty;
    logic [NUM_SOURCES-1:0]  ovf_set;
    logic                    fifo_flush;
    logic [SAMPLE_WIDTH-1:0] fifo_head [NUM_SOURCES];

    logic                    sel_valid;
    logic [CW-1:0]           sel_idx;
    logic [CW-1:0]           cand;
    logic [CW-1:0]           rr_ptr;
    logic                    avail_q;
    logic                    trig_q;
    logic                    trig_next;
    logic [NUM_SOURCES-1:0]  trig_en;

    assign wb_req     = wb_stb_i & wb_cyc_i;
    assign reg_wr     = wb_ack_o & wb_req & wb_we_i;
    assign fifo_flush = ~sq_active;
    assign unused_adr = &{1'b0, wb_adr_i[15:8]};

    // ---------------------------------------------------------------- registers
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        rd_data = 8'h00;
        case (wb_adr_i[7:0])
            ADDR_ENABLE:   rd_data[NUM_SOURCES-1:0] = enable_q;
            ADDR_DECIM:    rd_data = decim_q;
            ADDR_TRIGMODE: rd_data[1:0] = trigmode_q;
            ADDR_OVERFLOW: rd_data[NUM_SOURCES-1:0] = overflow_q;
            default:       ;
        endcase
    end

    // Ack is a single-cycle pulse; a held request is not re-acked back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 8'h00;
        end else begin
            wb_ack_o <= wb_req & ~wb_ack_o;
            wb_dat_o <= (wb_req & ~wb_ack_o) ? rd_data : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q   <= '0;
            decim_q    <= 8'h00;
            trigmode_q <= 2'b00;
            overflow_q <= '0;
        end else begin
            if (reg_wr) begin
                case (wb_adr_i[7:0])
                    ADDR_ENABLE:   enable_q   <= wb_dat_i[NUM_SOURCES-1:0];
                    ADDR_DECIM:    decim_q    <= wb_dat_i;
                    ADDR_TRIGMODE: trigmode_q <= wb_dat_i[1:0];
                    default:       ;
                endcase
            end
            // A new overflow in the clearing cycle must survive the clear.
            if (reg_wr && wb_adr_i[7:0] == ADDR_OVERFLOW)
                overflow_q <= (overflow_q & ~wb_dat_i[NUM_SOURCES-1:0]) | ovf_set;
            else
                overflow_q <= overflow_q | ovf_set;
        end
    end

    // ------------------------------------------------- decimation and buffering
    always_comb begin
        for (int n = 0; n < NUM_SOURCES; n++) begin
            chan_hit[n]  = sq_active & enable_q[n] & avails[n];
            accept[n]    = chan_hit[n] & (dec_cnt[n] == 8'd0);
            fifo_pop[n]  = sq_active & sel_valid & (sel_idx == CW'(n));
            fifo_push[n] = accept[n] & (~fifo_full[n] | fifo_pop[n]);
            ovf_set[n]   = accept[n] & fifo_full[n] & ~fifo_pop[n];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_SOURCES; n++) dec_cnt[n] <= 8'd0;
        end else begin
            for (int n = 0; n < NUM_SOURCES; n++) begin
                if (!sq_active)
                    dec_cnt[n] <= 8'd0;
                else if (chan_hit[n])
                    dec_cnt[n] <= accept[n] ? decim_q : dec_cnt[n] - 8'd1;
            end
        end
    end

    for (genvar n = 0; n < NUM_SOURCES; n++) begin : g_fifo
        sampfifo #(
            .WIDTH (SAMPLE_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (fifo_push[n]),
            .pop   (fifo_pop[n]),
            .flush (fifo_flush),
            .wdata (sources[n*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
            .rdata (fifo_head[n]),
            .full  (fifo_full[n]),
            .empty (fifo_empty[n])
        );
    end

    // ------------------------------------------------------ round-robin merge
    // Scan offsets high to low so the lowest offset from the pointer wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            cand = CW'(wrap_idx(int'(rr_ptr), i, NUM_SOURCES));
            if (!fifo_empty[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample      <= '0;
            sample_chan <= 3'd0;
            avail_q     <= 1'b0;
            rr_ptr      <= '0;
        end else if (!sq_active) begin
            avail_q <= 1'b0;
            rr_ptr  <= '0;
        end else begin
            avail_q <= sel_valid;
            if (sel_valid) begin
                sample      <= fifo_head[sel_idx];
                sample_chan <= 3'(sel_idx);
                rr_ptr      <= CW'(wrap_idx(int'(sel_idx), 1, NUM_SOURCES));
            end
        end
    end

    // --------------------------------------------------------------- trigger
    always_comb begin
        trig_en   = triggers & enable_q;
        trig_next = 1'b0;
        case (trigmode_q)
            TRIG_OR:  trig_next = |trig_en;
            TRIG_AND: trig_next = (enable_q != '0) && (trig_en == enable_q);
            default:  trig_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trig_q <= 1'b0;
        else        trig_q <= sq_active & trig_next;
    end

    // Strobes are forced low for as long as the capture window is closed.
    assign sample_avail = avail_q & sq_active;
    assign sq_trigger   = trig_q & sq_active;

endmodule
